reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
// Write-side front end for reg_file's single write port. Merges two result
// sources (ALU and load unit) into one A3/wd3/we3 stream: loads have priority,
// ALU results wait in a small FIFO. Also reports in-flight writes matching
// rs1/rs2 and supplies bypass data, so decode can forward or stall.
// PARAMETERS
// XLEN   32  data width; matches reg_file wd3/rd1/rd2
// AW     5   register address width (32 regs)
// DEPTH  4   ALU result FIFO entries; power of two, >=2
// PORTS
// clk        in   1     rising-edge clock, shared with reg_file
// rst        in   1     synchronous, active-high reset
// alu_valid  in   1     ALU result offered
// alu_ready  out  1     FIFO can accept: !full
// alu_rd     in   AW    ALU destination register
// alu_data   in   XLEN  ALU result
// ld_valid   in   1     load result present; always accepted
// ld_rd      in   AW    load destination register
// ld_data    in   XLEN  load result
// A3         out  AW    to reg_file A3
// wd3        out  XLEN  to reg_file wd3
// we3        out  1     to reg_file we3
// rs1, rs2   in   AW    decode read addresses; also drive reg_file A1/A2
// pend1/2    out  1     rs1/rs2 matches an in-flight write (comb.)
// byp1/2     out  XLEN  newest in-flight data for rs1/rs2 (comb.; 0 if !pend)
// wb_conflict out 1     sticky: load rd collided with a queued ALU rd
// BEHAVIOUR
// - Reset (sync, rst=1 at edge): FIFO empty, we3=0, A3=0, wd3=0,
//   wb_conflict=0. Reset mid-operation drops every queued entry; no write issues.
// - ALU handshake: transfer on alu_valid&&alu_ready at the edge. rd==0
//   transfers are accepted and discarded (never enqueued, never pending).
// - Load: ld_valid with ld_rd!=0 is selected that cycle. rd==0 is ignored.
// - Select each cycle: load if valid and rd!=0, else FIFO head if not empty,
//   else none. A3/wd3/we3 take the selection at the next edge. No selection:
//   we3=0; A3/wd3 hold their values.
// - FIFO pops only when the head is selected. A push and pop in the same cycle
//   leave the count unchanged. Push when full cannot occur: alu_ready=0.
// - Latency: load -> we3 high 1 cycle later; ALU into an empty FIFO with no
//   load -> we3 high 2 cycles after the transfer edge. Sustained loads starve
//   the FIFO; no fairness required.
// - Order: FIFO is strictly in order. Upstream guarantees no WAW between a
//   load and a queued ALU entry. If ld_valid and ld_rd!=0 match any queued rd,
//   wb_conflict sets and stays set until rst. The load is still written.
// - Forwarding: candidates are the valid FIFO entries plus the output register
//   while we3=1 (reg_file has not yet written it). rs==0 never pends. Priority:
//   newest FIFO entry (nearest the tail) > older entries > output register.
// - Pointers are log2(DEPTH) bits and wrap naturally. count is
//   log2(DEPTH)+1 bits; full = count==DEPTH.
// STRUCTURE
// - Shared package rv_pkg: XLEN, AW, REG_ZERO constant, typedef wb_entry_t
//   {rd, data}.
// - One sub-module: wb_fifo (sync FIFO of wb_entry_t; exposes all entries and
//   valid bits for the forwarding match). Select, output register and
//   forwarding compare stay in the top module.
// TESTING
// - rst held for 2 cycles, then released -> we3=0, alu_ready=1, pend1=pend2=0.
// - ALU rd=5, data=0xDEADBEEF, no loads -> we3=1, A3=5, wd3=0xDEADBEEF on the
//   2nd cycle after the transfer; rs1=5 gives pend1=1 and byp1=0xDEADBEEF until
//   the write edge.
// - ld_valid every cycle; 5 ALU pushes (rd=1..5) -> alu_ready=0 after 4; once
//   loads stop, rd 1,2,3,4 are written in order over 4 consecutive cycles.
// - Same cycle: load rd=7 data=0x11 and ALU rd=8 data=0x22 -> write (7,0x11)
//   first, then (8,0x22) the next cycle.
// - Queue rd=3 twice (0xA, then 0xB) behind a load stream; rs2=3 ->
//   byp2=0xB. Load rd=3 while queued -> wb_conflict=1 and stays set.
// - rd=0 on both sources -> no enqueue, we3 stays 0. rst mid-queue with 3
//   entries -> FIFO empties and no write follows.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file types: widths, the x0 constant and the writeback entry.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of writeback entries. Storage and per-slot valid bits are
// exported so the forwarding compare can scan every queued write.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             din,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  empty,
  output logic                  full,
  output wb_entry_t [DEPTH-1:0] ents,
  output logic [DEPTH-1:0]      vld,
  output logic [PW-1:0]         rptr
);
  logic [PW-1:0] wptr;
  logic [CW-1:0] count;

  // Pointers wrap naturally; push+pop together leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ents[wptr] <= din;
        wptr       <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PW-1:0] offs;
    offs = '0;
    vld  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs   = PW'(i) - rptr;
      vld[i] = {1'b0, offs} < count;
    end
  end

  assign head  = ents[rptr];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-port front end for reg_file: loads win, ALU results queue in a FIFO,
// and every in-flight write is visible to decode for forwarding/stall.
module reg_wb_arbiter #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int AW    = rv_pkg::AW,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic [AW-1:0]   A3,
  output logic [XLEN-1:0] wd3,
  output logic            we3,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            pend1,
  output logic            pend2,
  output logic [XLEN-1:0] byp1,
  output logic [XLEN-1:0] byp2,
  output logic            wb_conflict
);
  import rv_pkg::*;

  localparam int PW = $clog2(DEPTH);

  wb_entry_t             alu_ent, head;
  wb_entry_t [DEPTH-1:0] ents;
  logic [DEPTH-1:0]      vld;
  logic [PW-1:0]         rptr;
  logic                  empty, full;
  logic                  ld_sel, push, pop, ld_hit;

  // Writes to x0 are dropped on both sources; x0 ALU results still handshake.
  assign ld_sel    = ld_valid && (ld_rd != REG_ZERO);
  assign alu_ready = !full;
  assign push      = alu_valid && alu_ready && (alu_rd != REG_ZERO);
  assign pop       = !ld_sel && !empty;
  assign alu_ent   = '{rd: alu_rd, data: alu_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (alu_ent),
    .pop   (pop),
    .head  (head),
    .empty (empty),
    .full  (full),
    .ents  (ents),
    .vld   (vld),
    .rptr  (rptr)
  );

  // Output register: load first, else FIFO head; A3/wd3 hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      we3 <= 1'b0;
      A3  <= '0;
      wd3 <= '0;
    end else if (ld_sel) begin
      we3 <= 1'b1;
      A3  <= ld_rd;
      wd3 <= ld_data;
    end else if (!empty) begin
      we3 <= 1'b1;
      A3  <= head.rd;
      wd3 <= head.data;
    end else begin
      we3 <= 1'b0;
    end
  end

  // A load whose rd is already queued breaks the no-WAW upstream contract.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && ents[i].rd == ld_rd) ld_hit = 1'b1;
  end

  // Sticky conflict flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) wb_conflict <= 1'b0;
    else if (ld_sel && ld_hit) wb_conflict <= 1'b1;
  end

  // Forwarding scan: output register first, then FIFO oldest->newest so the
  // newest matching entry is the one left standing.
  always_comb begin
    logic [PW-1:0] idx;
    idx   = '0;
    pend1 = 1'b0;
    pend2 = 1'b0;
    byp1  = '0;
    byp2  = '0;
    if (we3 && A3 == rs1) begin pend1 = 1'b1; byp1 = wd3; end
    if (we3 && A3 == rs2) begin pend2 = 1'b1; byp2 = wd3; end
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if (vld[idx] && ents[idx].rd == rs1) begin pend1 = 1'b1; byp1 = ents[idx].data; end
      if (vld[idx] && ents[idx].rd == rs2) begin pend2 = 1'b1; byp2 = ents[idx].data; end
    end
    if (rs1 == REG_ZERO) begin pend1 = 1'b0; byp1 = '0; end
    if (rs2 == REG_ZERO) begin pend2 = 1'b0; byp2 = '0; end
  end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with a queue-based reference model and a
// writeback scoreboard.
module tb_reg_wb_arbiter;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk, rst;
  logic        alu_valid, alu_ready, ld_valid;
  logic [4:0]  alu_rd, ld_rd, A3, rs1, rs2;
  logic [31:0] alu_data, ld_data, wd3, byp1, byp2;
  logic        we3, pend1, pend2, wb_conflict;

  int checks = 0;
  int errors = 0;

  ent_t        alu_q[$];
  ent_t        wr_q[$];
  logic        m_we, m_conf;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;

  reg_wb_arbiter #(.XLEN(32), .AW(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .A3(A3), .wd3(wd3), .we3(we3),
    .rs1(rs1), .rs2(rs2),
    .pend1(pend1), .pend2(pend2), .byp1(byp1), .byp2(byp2),
    .wb_conflict(wb_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Reference forwarding: output register, then queued entries oldest->newest.
  function automatic void exp_fwd(input logic [4:0] rs, output logic p, output logic [31:0] d);
    p = 1'b0;
    d = '0;
    if (m_we && m_a3 == rs) begin p = 1'b1; d = m_wd; end
    foreach (alu_q[i])
      if (alu_q[i].rd == rs) begin p = 1'b1; d = alu_q[i].data; end
    if (rs == 5'd0) begin p = 1'b0; d = '0; end
  endfunction

  // One clock: check combinational outputs, advance the model, then check
  // the registered outputs just after the edge. xfer reports an ALU transfer.
  task automatic tick(output bit xfer);
    logic p;
    logic [31:0] d;
    ent_t e;
    bit ready;
    xfer = 1'b0;
    @(negedge clk);
    if (!rst) begin
      ready = alu_q.size() < DEPTH;
      chk("alu_ready", alu_ready, ready);
      exp_fwd(rs1, p, d);
      chk("pend1", pend1, p);
      chk("byp1", byp1, d);
      exp_fwd(rs2, p, d);
      chk("pend2", pend2, p);
      chk("byp2", byp2, d);
      if (ld_valid && ld_rd != 5'd0) begin
        foreach (alu_q[i]) if (alu_q[i].rd == ld_rd) m_conf = 1'b1;
        wr_q.push_back('{rd: ld_rd, data: ld_data});
      end else if (alu_q.size() > 0) begin
        wr_q.push_back(alu_q.pop_front());
      end
      if (alu_valid && ready) begin
        xfer = 1'b1;
        if (alu_rd != 5'd0) alu_q.push_back('{rd: alu_rd, data: alu_data});
      end
    end else begin
      alu_q.delete();
      wr_q.delete();
      m_conf = 1'b0;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_we = 1'b0; m_a3 = '0; m_wd = '0;
      chk("rst_we3", we3, 0);
      chk("rst_A3", A3, 0);
      chk("rst_wd3", wd3, 0);
    end else begin
      chk("we3", we3, wr_q.size() > 0);
      if (wr_q.size() > 0) begin
        e = wr_q.pop_front();
        m_we = 1'b1; m_a3 = e.rd; m_wd = e.data;
      end else begin
        m_we = 1'b0;
      end
      chk("A3", A3, m_a3);
      chk("wd3", wd3, m_wd);
    end
    chk("wb_conflict", wb_conflict, m_conf);
  endtask

  initial begin
    bit x;
    bit got;
    m_we = 0; m_conf = 0; m_a3 = '0; m_wd = '0;
    rst = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0; rs1 = 0; rs2 = 0;

    // Reset for two cycles.
    tick(x); tick(x);
    rst = 0;
    #1;
    chk("post_rst_alu_ready", alu_ready, 1);
    chk("post_rst_pend1", pend1, 0);
    chk("post_rst_pend2", pend2, 0);
    chk("post_rst_we3", we3, 0);

    // Single ALU write with forwarding until the write edge.
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; rs1 = 5;
    tick(x);
    alu_valid = 0;
    chk("alu_q_pend1", pend1, 1);
    chk("alu_q_byp1", byp1, 32'hDEADBEEF);
    chk("alu_lat1_we3", we3, 0);
    tick(x);
    chk("alu_lat2_we3", we3, 1);
    chk("alu_lat2_A3", A3, 5);
    chk("alu_lat2_wd3", wd3, 32'hDEADBEEF);
    chk("alu_out_pend1", pend1, 1);
    tick(x);
    chk("alu_done_pend1", pend1, 0);
    rs1 = 0;

    // Load stream starves the FIFO until it fills.
    ld_valid = 1; ld_rd = 20;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1; alu_rd = 5'(i); alu_data = 32'h50 + i; ld_data = 32'h100 + i;
      tick(x);
    end
    alu_rd = 5; alu_data = 32'h55; ld_data = 32'h200;
    chk("full_alu_ready", alu_ready, 0);
    tick(x); tick(x);
    chk("full_hold_alu_ready", alu_ready, 0);
    ld_valid = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick(x);
      got = x;
    end
    chk("rd5_transfer", got, 1);
    alu_valid = 0;
    for (int c = 0; c < 6; c++) tick(x);

    // Load and ALU in the same cycle.
    ld_valid = 1; ld_rd = 7; ld_data = 32'h11;
    alu_valid = 1; alu_rd = 8; alu_data = 32'h22;
    tick(x);
    ld_valid = 0; alu_valid = 0;
    chk("same_A3_ld", A3, 7);
    chk("same_wd3_ld", wd3, 32'h11);
    tick(x);
    chk("same_A3_alu", A3, 8);
    chk("same_wd3_alu", wd3, 32'h22);
    tick(x);

    // Newest-entry forwarding, then a colliding load.
    ld_valid = 1; ld_rd = 20; ld_data = 32'h300;
    alu_valid = 1; alu_rd = 3; alu_data = 32'hA;
    tick(x);
    alu_data = 32'hB;
    tick(x);
    alu_valid = 0; rs2 = 3;
    tick(x);
    chk("newest_pend2", pend2, 1);
    chk("newest_byp2", byp2, 32'hB);
    ld_rd = 3; ld_data = 32'h33;
    tick(x);
    chk("conflict_set", wb_conflict, 1);
    ld_valid = 0;
    for (int c = 0; c < 4; c++) tick(x);
    chk("conflict_sticky", wb_conflict, 1);
    rs2 = 0;

    // x0 on both sources: nothing queued or written.
    ld_valid = 1; ld_rd = 0; ld_data = 32'h77;
    alu_valid = 1; alu_rd = 0; alu_data = 32'h88;
    for (int c = 0; c < 3; c++) tick(x);
    chk("x0_we3", we3, 0);
    ld_valid = 0; alu_valid = 0;
    tick(x);

    // Reset mid-queue with three entries behind a load stream.
    ld_valid = 1; ld_rd = 20;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 5'(9 + i); alu_data = 32'h900 + i; ld_data = 32'h400 + i;
      tick(x);
    end
    alu_valid = 0; ld_valid = 0; rst = 1; rs1 = 9;
    tick(x);
    rst = 0;
    for (int c = 0; c < 4; c++) tick(x);
    chk("post_mid_rst_we3", we3, 0);
    chk("post_mid_rst_pend1", pend1, 0);
    chk("post_mid_rst_conflict", wb_conflict, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
